vol_ctrl: RTL and testbench

- Volume front end between the raw volume push-buttons and the voice and 7-segment stages.
- Debounces volUP/volDOWN, generates single steps plus auto-repeat while a button is held, and keeps a saturating volume level.
- Drives the level to the voice path, and a BCD word to the 7-segment `num` input.
- Single clock domain; all timing is derived from a one-cycle tick enable, not a divided clock.

---
 rtl/vol_ctrl_if.sv | 22 ++
 rtl/vol_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_vol_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vol_ctrl_if.sv
// Volume front-end bus: tick/button inputs toward vol_ctrl, level/BCD/mute outputs back.
interface vol_ctrl_if #(
  parameter int VOL_W = 4
);
  logic             tick;
  logic             volUP_btn;
  logic             volDOWN_btn;
  logic [VOL_W-1:0] vol_out;
  logic             vol_chg;
  logic [15:0]      num;
  logic             muted;

  modport master (
    output tick, volUP_btn, volDOWN_btn,
    input  vol_out, vol_chg, num, muted
  );

  modport slave (
    input  tick, volUP_btn, volDOWN_btn,
    output vol_out, vol_chg, num, muted
  );
endinterface

// File: rtl/vol_ctrl.sv
// Volume push-button front end: per-button debounce on tick, press/auto-repeat
// FSM, saturating level, registered level/BCD outputs.
// Optional macro VOL_MUTE_EN: pressing both buttons toggles a mute that forces
// vol_out to 0 while leaving the stored level and num untouched.
module vol_ctrl #(
  parameter int VOL_W      = 4,
  parameter int VOL_MAX    = 15,
  parameter int VOL_INIT   = 8,
  parameter int DB_LEN     = 4,
  parameter int REP_DELAY  = 32,
  parameter int REP_PERIOD = 8
) (
  input  logic      clk,
  input  logic      rst,
  vol_ctrl_if.slave bus
);

  localparam int CNT_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [VOL_W-1:0] LVL_MAX    = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] LVL_INIT   = VOL_W'(VOL_INIT);
  localparam logic [CNT_W-1:0] DELAY_END  = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(REP_PERIOD);
  localparam logic [15:0]      NUM_INIT   = {8'h00, 4'(VOL_INIT / 10), 4'(VOL_INIT % 10)};

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  // index 0 = up, index 1 = down
  logic [1:0] raw;
  logic [1:0] db_d;   // debounced level as it will be after this edge
  logic [1:0] step;   // step request per button for this edge

  logic             lock_q, lock_d;
  logic             muted_q, muted_d;
  logic [VOL_W-1:0] level_q, level_d;
  logic [VOL_W-1:0] vol_out_q, vol_out_d;
  logic             vol_chg_q, vol_chg_d;
  logic [15:0]      num_q, num_d;
  logic [7:0]       lvl8, tens8, ones8;

  assign raw = {bus.volDOWN_btn, bus.volUP_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [DB_LEN-1:0] hist_q, hist_d;
    logic              db_bit_q, db_bit_d;
    logic              rise;
    logic              step_bit;
    rep_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

    // Shift the raw level into the history on tick; accept only a full run of equal samples
    always_comb begin
      hist_d   = hist_q;
      db_bit_d = db_bit_q;
      if (bus.tick) begin
        hist_d = {hist_q[DB_LEN-2:0], raw[gi]};
        if (&hist_d)
          db_bit_d = 1'b1;
        else if (~|hist_d)
          db_bit_d = 1'b0;
      end
    end

    assign rise     = db_bit_d & ~db_bit_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign db_d[gi] = db_bit_d;
    assign step[gi] = step_bit;

    // Debounce and repeat-FSM state registers
    always_ff @(posedge clk) begin
      if (!rst) begin
        hist_q   <= '0;
        db_bit_q <= 1'b0;
        state_q  <= IDLE;
        cnt_q    <= '0;
      end else begin
        hist_q   <= hist_d;
        db_bit_q <= db_bit_d;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
      end
    end

    // Next state: lock or release parks the FSM; otherwise count ticks toward the next step
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (lock_d || !db_bit_d) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d = DELAY;
              cnt_d   = '0;
            end
          end
          DELAY: begin
            if (bus.tick) begin
              if (cnt_inc == DELAY_END) begin
                state_d = REPEAT;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
          REPEAT: begin
            if (bus.tick) begin
              if (cnt_inc == PERIOD_END)
                cnt_d = '0;
              else
                cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Output: one step on the accepted press, at the end of the delay and on every repeat period
    always_comb begin
      step_bit = 1'b0;
      if (!lock_d && db_bit_d) begin
        case (state_q)
          IDLE:    step_bit = rise;
          DELAY:   step_bit = bus.tick && (cnt_inc == DELAY_END);
          REPEAT:  step_bit = bus.tick && (cnt_inc == PERIOD_END);
          default: step_bit = 1'b0;
        endcase
      end
    end
  end

  // Lock engages when both buttons are accepted together and holds until both are released
  always_comb begin
    lock_d = lock_q ? (db_d[0] | db_d[1]) : (db_d[0] & db_d[1]);
  end

  // Saturating level update, mute toggle, and derived output values
  always_comb begin
    level_d = level_q;
    if (step[0] && (level_q < LVL_MAX))
      level_d = level_q + 1'b1;
    else if (step[1] && (level_q != '0))
      level_d = level_q - 1'b1;

`ifdef VOL_MUTE_EN
    muted_d = muted_q ^ (lock_d & ~lock_q);
`else
    muted_d = 1'b0;
`endif

    vol_out_d = muted_d ? '0 : level_d;
    vol_chg_d = (vol_out_d != vol_out_q);

    lvl8  = 8'(level_d);
    tens8 = lvl8 / 8'd10;
    ones8 = lvl8 % 8'd10;
    num_d = {8'h00, tens8[3:0], ones8[3:0]};
  end

  // Level, lock, mute and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q   <= LVL_INIT;
      vol_out_q <= LVL_INIT;
      vol_chg_q <= 1'b0;
      num_q     <= NUM_INIT;
      lock_q    <= 1'b0;
      muted_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      vol_out_q <= vol_out_d;
      vol_chg_q <= vol_chg_d;
      num_q     <= num_d;
      lock_q    <= lock_d;
      muted_q   <= muted_d;
    end
  end

  assign bus.vol_out = vol_out_q;
  assign bus.vol_chg = vol_chg_q;
  assign bus.num     = num_q;
  assign bus.muted   = muted_q;

endmodule

// File: tb/tb_vol_ctrl.sv
// Directed bench for vol_ctrl: debounce, press step, auto-repeat, saturation,
// two-button lock (and mute when VOL_MUTE_EN is defined), reset mid-hold.
module tb_vol_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   chg_cnt;

  vol_ctrl_if #(.VOL_W(4)) bus ();

  vol_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count vol_chg pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.vol_chg === 1'b1)
      chg_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one tick with the given raw button levels; returns at the negedge after the tick edge
  task automatic tick_n(input int n, input logic up, input logic dn);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.volUP_btn   = up;
      bus.volDOWN_btn = dn;
      bus.tick        = 1'b1;
      @(negedge clk);
      bus.tick        = 1'b0;
    end
  endtask

  logic [31:0] exp_mute;
  logic [31:0] exp_vol_locked;
  logic [31:0] exp_lock_chg;
  logic [31:0] exp_vol_relock;

  initial begin
    vectors     = 0;
    miscompares = 0;
    chg_cnt     = 0;
`ifdef VOL_MUTE_EN
    exp_mute       = 32'd1;
    exp_vol_locked = 32'd0;
    exp_lock_chg   = 32'd1;
    exp_vol_relock = 32'd0;
`else
    exp_mute       = 32'd0;
    exp_vol_locked = 32'd9;
    exp_lock_chg   = 32'd0;
    exp_vol_relock = 32'd10;
`endif

    rst             = 1'b0;
    bus.tick        = 1'b0;
    bus.volUP_btn   = 1'b0;
    bus.volDOWN_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vol_out", 32'(bus.vol_out), 32'd8);
    chk("reset_num", 32'(bus.num), 32'h0008);
    chk("reset_vol_chg", 32'(bus.vol_chg), 32'd0);
    chk("reset_muted", 32'(bus.muted), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single press
    chg_cnt = 0;
    tick_n(3, 1'b1, 1'b0);
    chk("press_before_4th", 32'(bus.vol_out), 32'd8);
    tick_n(1, 1'b1, 1'b0);
    chk("press_vol_out", 32'(bus.vol_out), 32'd9);
    chk("press_vol_chg", 32'(bus.vol_chg), 32'd1);
    chk("press_num", 32'(bus.num), 32'h0009);
    @(negedge clk);
    chk("press_chg_drop", 32'(bus.vol_chg), 32'd0);
    tick_n(4, 1'b0, 1'b0);
    chk("press_pulses", 32'(chg_cnt), 32'd1);

    // bouncing input never settles for 4 samples
    chg_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      tick_n(3, 1'b1, 1'b0);
      tick_n(1, 1'b0, 1'b0);
    end
    chk("bounce_vol_out", 32'(bus.vol_out), 32'd9);
    chk("bounce_pulses", 32'(chg_cnt), 32'd0);
    tick_n(4, 1'b0, 1'b0);

    // one down press back to 8
    tick_n(4, 1'b0, 1'b1);
    tick_n(4, 1'b0, 1'b0);
    chk("down_to_8", 32'(bus.vol_out), 32'd8);

    // hold up 200 ticks: 9 at tick 4, 10 at 36, then +1 every 8, hold at 15
    chg_cnt = 0;
    tick_n(3, 1'b1, 1'b0);
    chk("hold_t3", 32'(bus.vol_out), 32'd8);
    tick_n(1, 1'b1, 1'b0);
    chk("hold_t4", 32'(bus.vol_out), 32'd9);
    tick_n(31, 1'b1, 1'b0);
    chk("hold_t35", 32'(bus.vol_out), 32'd9);
    tick_n(1, 1'b1, 1'b0);
    chk("hold_t36", 32'(bus.vol_out), 32'd10);
    tick_n(7, 1'b1, 1'b0);
    chk("hold_t43", 32'(bus.vol_out), 32'd10);
    tick_n(1, 1'b1, 1'b0);
    chk("hold_t44", 32'(bus.vol_out), 32'd11);
    tick_n(32, 1'b1, 1'b0);
    chk("hold_t76", 32'(bus.vol_out), 32'd15);
    tick_n(124, 1'b1, 1'b0);
    chk("hold_t200", 32'(bus.vol_out), 32'd15);
    chk("hold_pulses", 32'(chg_cnt), 32'd7);
    chk("hold_num", 32'(bus.num), 32'h0015);
    tick_n(4, 1'b0, 1'b0);

    // hold down to 0 (0 reached at tick 140), then press down at 0
    tick_n(150, 1'b0, 1'b1);
    tick_n(4, 1'b0, 1'b0);
    chk("down_floor", 32'(bus.vol_out), 32'd0);
    chg_cnt = 0;
    tick_n(4, 1'b0, 1'b1);
    tick_n(4, 1'b0, 1'b0);
    chk("down_at_0_vol", 32'(bus.vol_out), 32'd0);
    chk("down_at_0_pulses", 32'(chg_cnt), 32'd0);
    chk("down_at_0_num", 32'(bus.num), 32'h0000);

    // hold up to 10 (reached at tick 100), then one down press
    tick_n(100, 1'b1, 1'b0);
    tick_n(4, 1'b0, 1'b0);
    chk("up_to_10", 32'(bus.vol_out), 32'd10);
    chk("num_10", 32'(bus.num), 32'h0010);
    tick_n(4, 1'b0, 1'b1);
    chk("down_from_10", 32'(bus.vol_out), 32'd9);
    chk("num_9", 32'(bus.num), 32'h0009);
    tick_n(4, 1'b0, 1'b0);

    // both buttons, then keep up alone
    chg_cnt = 0;
    tick_n(4, 1'b1, 1'b1);
    chk("both_vol_out", 32'(bus.vol_out), exp_vol_locked);
    chk("both_muted", 32'(bus.muted), exp_mute);
    tick_n(100, 1'b1, 1'b0);
    chk("lock_vol_out", 32'(bus.vol_out), exp_vol_locked);
    chk("lock_num", 32'(bus.num), 32'h0009);
    chk("lock_muted", 32'(bus.muted), exp_mute);
    chk("lock_pulses", 32'(chg_cnt), exp_lock_chg);
    tick_n(4, 1'b0, 1'b0);

    // after full release a new up press is honoured again
    tick_n(4, 1'b1, 1'b0);
    chk("relock_vol_out", 32'(bus.vol_out), exp_vol_relock);
    chk("relock_num", 32'(bus.num), 32'h0010);
    tick_n(4, 1'b0, 1'b0);

    // reset during auto-repeat with up still held: 11 at tick 4, 12 at tick 36
    tick_n(40, 1'b1, 1'b0);
    chk("pre_rst_num", 32'(bus.num), 32'h0012);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_vol_out", 32'(bus.vol_out), 32'd8);
    chk("rst_num", 32'(bus.num), 32'h0008);
    chk("rst_muted", 32'(bus.muted), 32'd0);
    tick_n(3, 1'b1, 1'b0);
    chk("rst_redebounce", 32'(bus.vol_out), 32'd8);
    tick_n(1, 1'b1, 1'b0);
    chk("rst_new_press", 32'(bus.vol_out), 32'd9);
    tick_n(4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
